// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - MIPS field encoder and instruction-memory loader
// Packs decoded fields into 32-bit words and writes them to consecutive addresses.
module instr_encode_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              full,
  output logic              err_illegal
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0] ONE = 1;

  state_t              state_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W:0]     count_q;
  logic                full_q;
  logic                err_q;

  logic                accept;
  logic                enc_legal;
  logic [31:0]         enc_word;
  logic [ADDR_W:0]     count_d;

  assign in_ready = (state_q == LOAD) && !full_q && !load_start;
  assign accept   = in_valid && in_ready;
  assign count_d  = count_q + ONE;

  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (in_op)
      3'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      3'd1:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      3'd2:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      3'd3:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
      3'd4:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
      default: enc_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (load_start) begin
        // Restart wins over load_end and the handshake; a pending strobe already left.
        state_q <= LOAD;
        count_q <= '0;
        full_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        if (accept) begin
          if (enc_legal) begin
            we_q    <= 1'b1;
            addr_q  <= BASE_ADDR + count_q[ADDR_W-1:0];
            wdata_q <= enc_word;
            count_q <= count_d;
            full_q  <= count_d[ADDR_W];
          end else begin
            err_q <= 1'b1;
          end
        end
        if (state_q == LOAD && load_end) state_q <= DONE;
      end
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign word_count  = count_q;
  assign busy        = (state_q == LOAD);
  assign full        = full_q;
  assign err_illegal = err_q;

endmodule
